// File: rtl/newton_div_arbiter.sv
// Round-robin front end sharing one Newton-Raphson divider between NREQ requesters (NORM_CHECK_EN adds reject of unnormalized operands).
// Latency: gnt one cycle after req, done six cycles after req with a 3-iteration divider (two when rejected).
// Backpressure: requesters hold req until gnt; no new grant is issued until the current result returns.
module newton_div_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   a_in,
    input  logic [32*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [31:0]          q_out,
    output logic                 err,
    output logic [31:0]          div_a,
    output logic [31:0]          div_b,
    output logic                 div_start,
    input  logic                 div_busy,
    input  logic                 div_ready,
    input  logic [31:0]          div_q
);

`ifdef NORM_CHECK_EN
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REJECT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic           any_req;
    logic [31:0]    a_sel;
    logic [31:0]    b_sel;
    logic [31:0]    op_a;
    logic [31:0]    op_b;

    // Scan downward so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        sel     = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                sel     = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel == IDW'(k)) begin
                a_sel = a_in[k*32 +: 32];
                b_sel = b_in[k*32 +: 32];
            end
        end
    end

`ifdef NORM_CHECK_EN
    logic norm_bad;
    logic err_q;
    assign norm_bad = ~a_sel[31] | ~b_sel[31];
    assign err      = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id      <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            q_out   <= '0;
            op_a    <= '0;
            op_b    <= '0;
`ifdef NORM_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt    <= NREQ'(1) << sel;
                        op_a   <= a_sel;
                        op_b   <= b_sel;
                        id     <= sel;
                        rr_ptr <= (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
`ifdef NORM_CHECK_EN
                        state  <= norm_bad ? REJECT : ISSUE;
`else
                        state  <= ISSUE;
`endif
                    end
                end
                ISSUE: state <= WAIT;
                // div_ready lingers from the previous operation; busy low qualifies it.
                WAIT: begin
                    if (div_ready && !div_busy) begin
                        q_out   <= div_q;
                        done    <= 1'b1;
                        done_id <= id;
`ifdef NORM_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        state   <= IDLE;
                    end
                end
`ifdef NORM_CHECK_EN
                REJECT: begin
                    q_out   <= '0;
                    done    <= 1'b1;
                    done_id <= id;
                    err_q   <= 1'b1;
                    state   <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign div_start = (state == ISSUE) && !clr;
    assign div_a     = op_a;
    assign div_b     = op_b;

endmodule

// File: tb/tb_newton_div_arbiter.sv
// Randomized bench for newton_div_arbiter with a 3-iteration divider stand-in and a timestamp-based scoreboard.
module tb_newton_div_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                clr;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  a_in;
    logic [32*NREQ-1:0]  b_in;
    logic [NREQ-1:0]     gnt;
    logic                done;
    logic [IDW-1:0]      done_id;
    logic [31:0]         q_out;
    logic                err;
    logic [31:0]         div_a;
    logic [31:0]         div_b;
    logic                div_start;
    logic                div_busy  = 1'b0;
    logic                div_ready = 1'b0;
    logic [31:0]         div_q     = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    newton_div_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .clr(clr), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .done_id(done_id), .q_out(q_out), .err(err),
        .div_a(div_a), .div_b(div_b), .div_start(div_start),
        .div_busy(div_busy), .div_ready(div_ready), .div_q(div_q)
    );

    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] n;
        n = {1'b0, a, 31'b0};
        return 32'(n / {32'b0, b});
    endfunction

    // Divider stand-in: busy for three cycles, then ready held high until the next start.
    int          dcnt = 0;
    logic [31:0] dq_pend = '0;
    always @(posedge clk) begin
        if (div_start) begin
            dcnt      <= 3;
            div_busy  <= 1'b1;
            div_ready <= 1'b0;
            div_q     <= $urandom;
            dq_pend   <= quot(div_a, div_b);
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                div_busy  <= 1'b0;
                div_ready <= 1'b1;
                div_q     <= dq_pend;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, tcur);
        end
    endtask

    // Scoreboard: expectations keyed by absolute cycle number (mod 16).
    int              tcur    = 0;
    int              free_at = 0;
    int              rr      = 0;
    logic [NREQ-1:0] e_gnt   [16];
    logic            e_start [16];
    logic            e_done  [16];
    logic            e_err   [16];
    logic [IDW-1:0]  e_id    [16];
    logic [31:0]     e_q     [16];
    logic [31:0]     last_q  = '0;
    bit              rst_chk = 0;
    bit              outst   [NREQ];

    task automatic clear_slot(input int s);
        e_gnt[s] = '0; e_start[s] = 1'b0; e_done[s] = 1'b0;
        e_err[s] = 1'b0; e_id[s] = '0; e_q[s] = '0;
    endtask

    task automatic model_eval();
        int sel;
        int s;
        logic [31:0] a;
        logic [31:0] b;
        bit bad;
        sel = -1;
        if (clr) begin
            for (int k = 0; k < 16; k++) clear_slot(k);
            for (int k = 0; k < NREQ; k++) outst[k] = 0;
            rr = 0; free_at = tcur + 1; last_q = '0; rst_chk = 1;
        end else if (tcur >= free_at && req != 0) begin
            for (int k = 0; k < NREQ; k++)
                if (sel < 0 && req[(rr + k) % NREQ]) sel = (rr + k) % NREQ;
            a = a_in[32*sel +: 32];
            b = b_in[32*sel +: 32];
`ifdef NORM_CHECK_EN
            bad = !a[31] || !b[31];
`else
            bad = 0;
`endif
            s = (tcur + 1) % 16;
            e_gnt[s] = NREQ'(1) << sel;
            if (bad) begin
                s = (tcur + 2) % 16;
                e_done[s] = 1'b1; e_id[s] = IDW'(sel); e_q[s] = '0; e_err[s] = 1'b1;
                free_at = tcur + 2;
            end else begin
                e_start[(tcur + 1) % 16] = 1'b1;
                s = (tcur + 6) % 16;
                e_done[s] = 1'b1; e_id[s] = IDW'(sel); e_q[s] = quot(a, b); e_err[s] = 1'b0;
                free_at = tcur + 6;
            end
            rr = (sel + 1) % NREQ;
        end
    endtask

    task automatic check_cycle();
        int s;
        s = tcur % 16;
        if (e_done[s]) last_q = e_q[s];
        chk("gnt", gnt, e_gnt[s]);
        chk("div_start", div_start, e_start[s]);
        chk("done", done, e_done[s]);
        chk("q_out", q_out, last_q);
        if (e_done[s]) begin
            chk("done_id", done_id, e_id[s]);
            chk("err", err, e_err[s]);
            outst[e_id[s]] = 0;
        end
        if (gnt != 0) chk("gnt_vs_busy", div_busy, 0);
        if (rst_chk) begin
            chk("rst_done_id", done_id, 0);
            chk("rst_err", err, 0);
            chk("rst_div_a", div_a, 0);
            chk("rst_div_b", div_b, 0);
            rst_chk = 0;
        end
        clear_slot(s);
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        tcur++;
        check_cycle();
        for (int k = 0; k < NREQ; k++) if (gnt[k]) req[k] = 1'b0;
    endtask

    task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
        req[i] = 1'b1;
        a_in[32*i +: 32] = a;
        b_in[32*i +: 32] = b;
        outst[i] = 1;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        v[31] = 1'b1;
`ifdef NORM_CHECK_EN
        if ($urandom_range(0, 7) == 0) v[31] = 1'b0;
`endif
        return v;
    endfunction

    initial begin
        clr = 1'b1; req = '0; a_in = '0; b_in = '0;
        for (int k = 0; k < 16; k++) clear_slot(k);
        for (int k = 0; k < NREQ; k++) outst[k] = 0;
        step(); step();
        clr = 1'b0;

        post(0, 32'h8000_0000, 32'h8000_0000);
        repeat (8) step();
        chk("single_q", q_out, 32'h8000_0000);

        post(1, 32'h8000_0000, 32'hC000_0000);
        post(3, 32'h8000_0000, 32'hC000_0000);
        repeat (14) step();
        chk("pair_q", q_out, 32'h5555_5555);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NREQ; k++) post(k, {1'b1, 31'($urandom)}, {1'b1, 31'($urandom)});
            repeat (26) step();
        end

        post(1, 32'h9000_0000, 32'hA000_0000);
        repeat (4) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (6) step();
        post(2, 32'h8000_0000, 32'hC000_0000);
        repeat (8) step();
        chk("after_rst_q", q_out, 32'h5555_5555);

`ifdef NORM_CHECK_EN
        post(2, 32'h8000_0000, 32'h4000_0000);
        repeat (4) step();
        chk("reject_q", q_out, 0);
`endif

        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < NREQ; k++)
                if (!outst[k] && $urandom_range(0, 3) == 0) post(k, rand_op(), rand_op());
            step();
        end
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/newton_div_arbiter.md
Name: newton_div_arbiter

Overview:
- Shares one Newton-Raphson divider (3-iteration, start/busy/ready handshake) between NREQ requesters using round-robin arbitration.
- Latches the granted requester's operands, pulses the divider start, and waits for divider ready.
- Returns the quotient to the granted requester with a one-cycle done pulse and the requester's ID.
- Sits between client pipelines and the single divider instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of done_id; must satisfy 2^IDW >= NREQ

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
req  in  NREQ  per-requester request level
a_in  in  32*NREQ  dividend of requester i at bits [32i+31:32i], format .1xxxxx
b_in  in  32*NREQ  divisor of requester i, same packing and format
gnt  out  NREQ  one-hot one-cycle grant pulse, registered
done  out  1  one-cycle result-valid pulse, registered
done_id  out  IDW  index of the requester that owns the result
q_out  out  32  quotient, format x.xxxxx, held until next done
err  out  1  valid with done; always 0 unless the optional feature is enabled
div_a  out  32  dividend to divider, held from latch
div_b  out  32  divisor to divider, held from latch
div_start  out  1  divider start, high for exactly one cycle per operation
div_busy  in  1  divider busy
div_ready  in  1  divider ready; stays high after completion until the next start
div_q  in  32  divider quotient

Behaviour:
- Reset (clr=1 at posedge): state=IDLE, rr_ptr=0, gnt=0, done=0, done_id=0, q_out=0, err=0, latched operands=0. div_start=0 during reset.
- Reset mid-operation abandons the operation with no done. The divider is not reset by this block. A stale div_ready is ignored because it is only sampled in WAIT.
- FSM states: IDLE, ISSUE, WAIT, and REJECT (REJECT exists only with the optional feature).
- IDLE: if any req is high, select the first asserted index at or after rr_ptr, wrapping modulo NREQ.
  - At the edge: gnt[sel]<=1, latch a_in/b_in slice sel, id<=sel, rr_ptr<=(sel+1) mod NREQ, state<=ISSUE.
  - With no req, stay in IDLE and leave rr_ptr unchanged.
- ISSUE: div_start=1, decoded combinationally from state. At the edge, state<=WAIT.
- WAIT: div_start=0. When div_ready=1 and div_busy=0, at the edge: q_out<=div_q, done<=1, done_id<=id, err<=0, state<=IDLE. Otherwise stay in WAIT. There is no timeout.
- gnt and done are single-cycle pulses and are cleared on the following edge.
- Timing with the 3-iteration divider: req sampled in cycle n; gnt visible in n+1; div_start in n+1; div_ready seen in n+5; done in n+6.
  - IDLE is re-entered in n+6, so the next grant can be sampled in n+6.
  - Sustained throughput is one result per 6 cycles.
- Requester rules:
  - Hold req and operands stable until gnt is observed.
  - Drop req in the cycle gnt is seen, or it is treated as a new request.
  - A req still high in the done cycle is arbitrated normally in that IDLE cycle.
- div_a and div_b come from the latched operands and stay stable from ISSUE through WAIT.
- Each requester has at most one operation outstanding. The arbiter never issues while state is not IDLE.

Optional Feature:
NORM_CHECK_EN
- Defined: in IDLE, if the selected requester's a_in[31]=0 or b_in[31]=0 (not normalized):
  - Grant and rr_ptr update happen as normal, but state<=REJECT and the divider is not started.
  - REJECT: at the edge, done<=1, done_id<=id, q_out<=0, err<=1, state<=IDLE. done is visible 2 cycles after the req sample.
- Undefined: no check and no REJECT state. err is tied 0 and all operands go to the divider.

Test Plan:
- Single request: req=4'b0001, a=0x80000000, b=0x80000000. Expect gnt[0] in cycle n+1, one div_start, done in n+6 with done_id=0 and q_out=0x80000000 ±1 LSB.
- Two simultaneous requests: req=4'b1010 with rr_ptr=0, a=0x80000000, b=0xC0000000. Expect grant to 1 then 3, done_id sequence 1,3, each q_out=0x55555555 ±1 LSB.
- All four requesters re-request after each done. Expect grant order 0,1,2,3,0, exactly one div_start per grant, and no overlap between gnt and busy.
- Reset asserted during WAIT. Expect no done, all outputs 0 the next cycle, and the next req=4'b0100 granted to index 2 with correct result.
- Stale ready: after a completed operation (div_ready stays 1), issue a new request. Expect no done until div_busy has dropped and div_ready rises again (done in n+6).
- NORM_CHECK_EN defined: req[2] with b=0x40000000. Expect gnt[2], no div_start, done 2 cycles after sample with err=1, q_out=0, done_id=2.
